// File: rtl/frame_buf_reader.sv
// frame_buf_reader: read-side engine of the single-clock BRAM frame buffer.
// It takes a descriptor (start address, byte length) and reads the frame out of
// a BRAM with one-cycle registered read latency. The bytes leave as a
// valid/ready stream with end-of-frame marking, and o_done pulses on completion.
//
// Handshake rules: a transfer happens on a clock edge where valid and ready are
// both high. A producer never withdraws valid, and never changes the data it
// offers, before ready is seen. Ready never depends on the partner's valid.
//
// Optional feature: define FRAME_BUF_READER_PAD_EN to pad frames shorter than
// 60 bytes with 0x00 bytes up to 60. The pad bytes do not read the BRAM.
//
// Read pipeline: a read is "issued" on the edge where the BRAM captures
// o_rd_addr. On that edge o_rd_addr advances to the next byte and the in-flight
// flag is set. The captured byte sits on i_rd_data for one cycle and is pushed
// into a 2-entry output buffer on the next edge. Reads are throttled so that
// buffer plus in-flight never exceeds two bytes.
module frame_buf_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_desc_valid,
    output logic                  o_desc_ready,
    input  logic [ADDR_WIDTH-1:0] i_desc_addr,
    input  logic [LEN_WIDTH-1:0]  i_desc_len,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_tx_last,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    localparam int unsigned LAST_ADDR = DEPTH - 1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [LEN_WIDTH-1:0]  len_q;       // bytes to emit, including any padding
    logic [LEN_WIDTH-1:0]  issued_q;    // bytes requested so far (reads + pads)
    logic [LEN_WIDTH-1:0]  accepted_q;  // bytes handshaken downstream so far
    logic                  infl_q;      // i_rd_data (or a pad) is due in the buffer
    logic [DATA_WIDTH-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  busy_q, done_q, desc_ready_q;

    logic                  tx_valid, pop, push, issue, pad_issue, last_beat;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] push_data;
    logic [LEN_WIDTH-1:0]  desc_total;
    logic [ADDR_WIDTH-1:0] next_addr;

`ifdef FRAME_BUF_READER_PAD_EN
    localparam logic [LEN_WIDTH-1:0] MIN_FRAME = LEN_WIDTH'(60);

    logic [LEN_WIDTH-1:0] real_len_q;   // bytes that come from the BRAM
    logic                 infl_pad_q;   // the in-flight byte is a pad, not BRAM data

    assign desc_total = (i_desc_len != '0 && i_desc_len < MIN_FRAME) ? MIN_FRAME : i_desc_len;
    assign pad_issue  = (issued_q >= real_len_q);
    assign push_data  = infl_pad_q ? '0 : i_rd_data;
`else
    assign desc_total = i_desc_len;
    assign pad_issue  = 1'b0;
    assign push_data  = i_rd_data;
`endif

    assign tx_valid  = (cnt_q != 2'd0);
    assign pop       = tx_valid & i_tx_ready;
    assign push      = infl_q;
    assign last_beat = (accepted_q == len_q - 1'b1);
    assign occ       = {1'b0, cnt_q} + {2'b00, infl_q};
    assign issue     = (state_q == S_READ) && ((occ - {2'b00, pop}) < 3'd2) && (issued_q < len_q);
    assign next_addr = (rd_addr_q == ADDR_WIDTH'(LAST_ADDR)) ? '0 : rd_addr_q + 1'b1;

    assign o_desc_ready = desc_ready_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_tx_data    = buf0_q;
    assign o_tx_valid   = tx_valid;
    assign o_tx_last    = tx_valid & last_beat;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

    // Output buffer next state: push the in-flight byte and pop the head, in any combination
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = push_data;
                else               buf1_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = push_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // Control FSM with registered outputs, plus read issue, counters and buffer registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            accepted_q   <= '0;
            infl_q       <= 1'b0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            cnt_q        <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            desc_ready_q <= 1'b0;
`ifdef FRAME_BUF_READER_PAD_EN
            real_len_q   <= '0;
            infl_pad_q   <= 1'b0;
`endif
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            cnt_q  <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    desc_ready_q <= 1'b1;
                    if (i_desc_valid && desc_ready_q) begin
                        desc_ready_q <= 1'b0;
                        len_q        <= desc_total;
                        issued_q     <= '0;
                        accepted_q   <= '0;
                        infl_q       <= 1'b0;
`ifdef FRAME_BUF_READER_PAD_EN
                        real_len_q   <= i_desc_len;
                        infl_pad_q   <= 1'b0;
`endif
                        if (i_desc_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_READ;
                            busy_q    <= 1'b1;
                            rd_addr_q <= i_desc_addr;
                        end
                    end
                end
                S_READ: begin
                    infl_q <= issue;
`ifdef FRAME_BUF_READER_PAD_EN
                    infl_pad_q <= issue & pad_issue;
`endif
                    if (issue) begin
                        issued_q <= issued_q + 1'b1;
                        if (!pad_issue) rd_addr_q <= next_addr;
                    end
                    if (pop) begin
                        accepted_q <= accepted_q + 1'b1;
                        if (last_beat) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q       <= 1'b0;
                    desc_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_buf_reader.sv
// Directed testbench for frame_buf_reader: a BRAM model with one-cycle
// registered read latency feeds the DUT, and a collector records the output
// stream. Each test task checks its own results against an expected queue
// that is built from the memory contents.
`timescale 1ns/1ps
module tb_frame_buf_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid;
    logic        desc_ready;
    logic [7:0]  desc_addr;
    logic [10:0] desc_len;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last, tx_ready, busy, done;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    // Results of the most recent collect() call
    int first_valid_cyc, last_idx, last_cnt, last_hs_cyc, done_cyc, stall_bad, addr_changes;
    bit timed_out, busy_bad, saw_addr_zero;

    // ---------------- clock / reset / BRAM ----------------
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    frame_buf_reader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_desc_valid(desc_valid),
        .o_desc_ready(desc_ready),
        .i_desc_addr (desc_addr),
        .i_desc_len  (desc_len),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_tx_last   (tx_last),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_done      (done)
    );

    // ---------------- model / drivers ----------------
    task automatic build_exp(input logic [7:0] a, input int n);
        logic [7:0] ad;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            exp_q.push_back(mem[ad]);
        end
`ifdef FRAME_BUF_READER_PAD_EN
        if (n > 0 && n < 60) while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif
    endtask

    // Waits (bounded) for o_desc_ready, then offers one descriptor for one edge
    task automatic send_desc(input logic [7:0] a, input logic [10:0] n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (desc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            desc_valid = 1'b1;
            desc_addr  = a;
            desc_len   = n;
            @(posedge clk);
            #1;
            desc_valid = 1'b0;
            desc_addr  = 8'h00;
            desc_len   = 11'd0;
        end
    endtask

    // Records the output stream, one sample per negedge. Cycle 0 is the first
    // negedge after the accept edge. mode 0: ready always 1; mode 1: ready 1,0,0,1.
    // Stops at o_done or when max_cyc runs out (timed_out stays 1).
    task automatic collect(input int mode, input bit expect_busy, input int max_cyc);
        bit         prev_valid, prev_ready;
        logic [7:0] prev_data, prev_addr;
        got_q.delete();
        first_valid_cyc = -1; last_idx = -1; last_cnt = 0; last_hs_cyc = -1;
        done_cyc = -1; stall_bad = 0; addr_changes = 0;
        timed_out = 1'b1; busy_bad = 1'b0; saw_addr_zero = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00; prev_addr = 8'h00;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            tx_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (c == 0) prev_addr = rd_addr;
            else if (rd_addr != prev_addr) begin
                addr_changes++;
                prev_addr = rd_addr;
            end
            if (rd_addr == 8'h00) saw_addr_zero = 1'b1;
            if (prev_valid && !prev_ready && (!tx_valid || tx_data !== prev_data)) stall_bad++;
            if (done) begin
                done_cyc  = c;
                timed_out = 1'b0;
                if (busy) busy_bad = 1'b1;
                break;
            end
            if (busy !== expect_busy) busy_bad = 1'b1;
            if (tx_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (tx_last) begin
                    last_idx    = got_q.size() - 1;
                    last_cnt++;
                    last_hs_cyc = c;
                end
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
        end
        tx_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        #12;
        n_vec++; if (desc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_desc_ready got %b exp 0", desc_ready); end
        n_vec++; if (rd_addr !== 8'h00) begin n_fail++; $display("FAIL rst_rd_addr got %h exp 00", rd_addr); end
        n_vec++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
        n_vec++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
        n_vec++; if (tx_last !== 1'b0) begin n_fail++; $display("FAIL rst_tx_last got %b exp 0", tx_last); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (desc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b exp 1", desc_ready); end
    endtask

    task automatic test_basic;
        bit ok;
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 8'hA0 + 8'(i);
        build_exp(8'h10, 4);
        send_desc(8'h10, 11'd4, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL basic_accept got timeout exp accept"); end
        collect(0, 1'b1, 200);
        n_vec++; if (timed_out) begin n_fail++; $display("FAIL basic_done got no o_done exp o_done"); end
        n_vec++; if (first_valid_cyc != 2) begin n_fail++; $display("FAIL basic_latency got %0d exp 2", first_valid_cyc); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (last_idx != exp_q.size() - 1 || last_cnt != 1) begin n_fail++; $display("FAIL basic_last got idx %0d cnt %0d exp idx %0d cnt 1", last_idx, last_cnt, exp_q.size() - 1); end
        n_vec++; if (done_cyc != exp_q.size() + 2) begin n_fail++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc, exp_q.size() + 2); end
        n_vec++; if (busy_bad) begin n_fail++; $display("FAIL basic_busy got wrong o_busy exp 1 until o_done"); end
        n_vec++; if (addr_changes != 4) begin n_fail++; $display("FAIL basic_reads got %0d exp 4", addr_changes); end
        @(negedge clk);
        n_vec++; if (desc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after got %b exp 1", desc_ready); end
    endtask

    task automatic test_wrap;
        bit ok;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        build_exp(8'hFE, 4);
        send_desc(8'hFE, 11'd4, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL wrap_accept got timeout exp accept"); end
        collect(0, 1'b1, 200);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (!saw_addr_zero) begin n_fail++; $display("FAIL wrap_addr got no 00 exp rd_addr 00"); end
        n_vec++; if (addr_changes != 4) begin n_fail++; $display("FAIL wrap_reads got %0d exp 4", addr_changes); end
        n_vec++; if (last_idx != exp_q.size() - 1) begin n_fail++; $display("FAIL wrap_last got %0d exp %0d", last_idx, exp_q.size() - 1); end
    endtask

    task automatic test_backpressure;
        bit ok;
        for (int i = 0; i < 8; i++) mem[8'h20 + i] = 8'h50 + 8'(3 * i);
        build_exp(8'h20, 8);
        send_desc(8'h20, 11'd8, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL bp_accept got timeout exp accept"); end
        collect(1, 1'b1, 500);
        n_vec++; if (timed_out) begin n_fail++; $display("FAIL bp_done got no o_done exp o_done"); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_bad); end
        n_vec++; if (done_cyc != last_hs_cyc + 1) begin n_fail++; $display("FAIL bp_done_cyc got %0d exp %0d", done_cyc, last_hs_cyc + 1); end
        n_vec++; if (addr_changes != 8) begin n_fail++; $display("FAIL bp_reads got %0d exp 8", addr_changes); end
    endtask

    task automatic test_zero_len;
        bit ok;
        send_desc(8'h00, 11'd0, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL zero_accept got timeout exp accept"); end
        collect(0, 1'b0, 50);
        n_vec++; if (done_cyc != 0) begin n_fail++; $display("FAIL zero_done_cyc got %0d exp 0", done_cyc); end
        n_vec++; if (got_q.size() != 0 || first_valid_cyc != -1) begin n_fail++; $display("FAIL zero_no_data got %0d bytes exp 0", got_q.size()); end
        n_vec++; if (busy_bad) begin n_fail++; $display("FAIL zero_busy got o_busy 1 exp 0"); end
        @(negedge clk);
        n_vec++; if (desc_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after got %b exp 1", desc_ready); end
    endtask

    task automatic test_reset_mid_frame;
        bit ok, done_seen;
        int hs;
        for (int i = 0; i < 10; i++) mem[8'h50 + i] = 8'hC0 + 8'(i);
        for (int i = 0; i < 5; i++) mem[8'h60 + i] = 8'h70 + 8'(7 * i);
        send_desc(8'h50, 11'd10, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL mid_accept got timeout exp accept"); end
        tx_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_valid) hs++;
            if (hs == 3) break;
        end
        n_vec++; if (hs != 3) begin n_fail++; $display("FAIL mid_progress got %0d bytes exp 3", hs); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx got v%b l%b d%h exp v0 l0 d00", tx_valid, tx_last, tx_data); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || desc_ready !== 1'b0 || rd_addr !== 8'h00) begin n_fail++; $display("FAIL mid_rst_ctl got busy%b done%b rdy%b addr%h exp 0 0 0 00", busy, done, desc_ready, rd_addr); end
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        rst = 1'b0;
        @(negedge clk);
        if (done) done_seen = 1'b1;
        n_vec++; if (desc_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got %b exp 1", desc_ready); end
        n_vec++; if (done_seen) begin n_fail++; $display("FAIL mid_no_done got o_done 1 exp 0"); end
        build_exp(8'h60, 5);
        send_desc(8'h60, 11'd5, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL mid_next_accept got timeout exp accept"); end
        collect(0, 1'b1, 200);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_next_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_next_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (last_idx != exp_q.size() - 1) begin n_fail++; $display("FAIL mid_next_last got %0d exp %0d", last_idx, exp_q.size() - 1); end
    endtask

`ifdef FRAME_BUF_READER_PAD_EN
    task automatic test_pad;
        bit ok;
        for (int i = 0; i < 20; i++) mem[8'h40 + i] = 8'h80 + 8'(i);
        build_exp(8'h40, 10);
        send_desc(8'h40, 11'd10, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL pad_accept got timeout exp accept"); end
        collect(0, 1'b1, 300);
        n_vec++; if (got_q.size() != 60) begin n_fail++; $display("FAIL pad_count got %0d exp 60", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pad_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (last_idx != 59 || last_cnt != 1) begin n_fail++; $display("FAIL pad_last got idx %0d cnt %0d exp 59 1", last_idx, last_cnt); end
        n_vec++; if (addr_changes != 10) begin n_fail++; $display("FAIL pad_reads got %0d exp 10", addr_changes); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        desc_valid = 1'b0;
        desc_addr  = 8'h00;
        desc_len   = 11'd0;
        tx_ready   = 1'b1;
        rst        = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(255, 1));
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid_frame();
`ifdef FRAME_BUF_READER_PAD_EN
        test_pad();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
